count_mod: RTL
==============

Name: count_mod

Overview:
- Parametrised up/down modulus counter; next generation of the team's fixed counter DUT.
- Adds runtime-programmable upper bound, direction control, and wrap/saturate mode.
- Adds synchronous load, a registered terminal-count pulse, and a sticky overflow flag.
- Driven from the bench interface like its predecessor: same clock and reset nets, DUT instantiated in the testbench top.

Parameters:
- WIDTH, 8, counter and bound width in bits (legal 2..32).
- RST_VAL, 0, count value after reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- dir  input  1  1 = count up, 0 = count down.
- sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
- max_val  input  WIDTH  inclusive upper bound; legal count range is 0..max_val.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value applied on load.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  registered count value.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky boundary-event flag.

Behaviour:
- Reset: rst sampled high at a rising edge sets count=RST_VAL, tc=0, ovf=0. rst overrides all other inputs. A reset mid-count takes effect on that edge.
- Priority per edge: rst > load > en.
- Load:
  - count <= min(load_val, max_val).
  - tc=0; ovf unchanged; en ignored that cycle.
- Hold: en=0 and load=0 -> count holds, tc=0.
- Boundary event: an enabled step (en=1, load=0) with dir=1 and count==max_val, or with dir=0 and count==0.
- Normal enabled step (not a boundary, count<=max_val): count +1 (up) or -1 (down); tc=0.
- Boundary with sat=0 (wrap): up -> count=0; down -> count=max_val.
- Boundary with sat=1 (saturate): count holds at max_val (up) or 0 (down).
- Every boundary event, in either mode:
  - tc=1 on the next cycle (registered with count).
  - ovf <= 1.
  - Consecutive boundary events in saturate mode give tc high on consecutive cycles.
- Out-of-range count (count>max_val, e.g. after max_val is lowered at runtime): an enabled step in either direction sets count=max_val, tc=0, ovf unchanged. en=0 -> holds.
- max_val=0: count stays 0. Every enabled step is a boundary event (tc=1, ovf set) in both modes.
- ovf:
  - Set by a boundary event, cleared by clr_ovf.
  - If set and clear coincide on the same edge, set wins (ovf=1).
  - Cleared only by clr_ovf or rst.
- Input timing: dir, sat and max_val may change on any cycle and take effect on the edge where they are sampled.
- Latency: count, tc and ovf reflect inputs sampled on the previous rising edge.
- No combinational input-to-output paths.
- Arithmetic is WIDTH-bit unsigned. With max_val=2^WIDTH-1 the counter behaves as a plain WIDTH-bit up/down counter.

Test Plan:
- Reset: WIDTH=8, RST_VAL=5; rst high 2 cycles with en=1, load=1, load_val=9 -> count=5, tc=0, ovf=0 after reset; first enabled up-step gives 6.
- Wrap up: max_val=9, sat=0, dir=1, en=1 from count=0 -> sequence 0..9, then 0 with tc=1 for exactly that one cycle, ovf=1; clr_ovf pulse -> ovf=0.
- Saturate down: load_val=2, max_val=9, sat=1, dir=0, en=1 for 5 cycles -> count 2,1,0,0,0; tc=1 on the two cycles after the hold steps; ovf=1.
- Load clamp and priority:
  - load=1, en=1, load_val=200, max_val=50 -> count=50, tc=0.
  - Next cycle load=0, en=1, dir=1, sat=0 -> count=0, tc=1.
- Runtime bound change: count=40, max_val lowered to 10 with en=1, dir=0 -> count=10, tc=0; then decrements 9, 8, ...
- Simultaneous and mid-operation events:
  - clr_ovf=1 on the same edge as a boundary event -> ovf stays 1.
  - rst asserted mid-count at count=7 -> next cycle count=RST_VAL, ovf=0.

Source files
------------

// File: rtl/count_mod.sv
// Up/down modulus counter with a runtime-programmable inclusive bound, wrap/saturate
// boundary mode, synchronous load, a registered terminal-count pulse and a sticky overflow flag.
module count_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] max_val_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic out_of_range;
    logic at_boundary;

    assign out_of_range = (count_q > max_val_i);
    assign at_boundary  = dir_i ? (count_q == max_val_i) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf_i;

        if (load_i) begin
            count_d = (load_val_i > max_val_i) ? max_val_i : load_val_i;
        end else if (en_i) begin
            if (out_of_range) begin
                // Bound was lowered beneath the count: snap back into range, no event.
                count_d = max_val_i;
            end else if (at_boundary) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (!sat_i) begin
                    count_d = dir_i ? '0 : max_val_i;
                end
            end else begin
                count_d = dir_i ? (count_q + One) : (count_q - One);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= RstCount;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule
